// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for the EX stage (DIV/DIVU).
// Produces one quotient bit per cycle and holds the EX stall request
// until the registered {remainder, quotient} result is presented.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             q_neg, r_neg;

  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // Operand magnitudes and one restoring step on {rem, quo}.
  // The most-negative value keeps its bit pattern, which reads
  // correctly as an unsigned magnitude.
  always_comb begin
    abs1    = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2    = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = shifted >= {1'b0, dvs};
    rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

  // The pipeline stays frozen until the result cycle.
  assign stallreq_o = start_i & ~ready_o;

  // Control FSM and datapath registers; result and ready are registered
  // on the transition into S_END.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_o <= 1'b0;
          if (start_i & ~annul_i) begin
            rem   <= '0;
            quo   <= abs1;
            dvs   <= abs2;
            cnt   <= '0;
            q_neg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg <= signed_div_i & opdata1_i[WIDTH-1];
            state <= (opdata2_i == '0) ? S_DIVZERO : S_ON;
          end
        end
        S_DIVZERO: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            result_o <= '0;
            ready_o  <= 1'b1;
            state    <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) begin
              result_o <= {(r_neg ? -rem_nxt : rem_nxt),
                           (q_neg ? -quo_nxt : quo_nxt)};
              ready_o  <= 1'b1;
              state    <= S_END;
            end
          end
        end
        default: begin
          // Result cycle: start_i is ignored so the parked instruction
          // is not accepted a second time.
          ready_o <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus hand sequences for annul,
// back-to-back, idle-annul and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, annul_i, signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive point is posedge+1, sample point is the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the drive point of cycle 0. Returns the cycle ready_o is
  // seen (-1 if the bound expires) and the stall cycles observed.
  task automatic wait_ready(input int limit, input bit scramble,
                            output int lat, output logic [63:0] res, output int stalls);
    lat    = -1;
    res    = '0;
    stalls = 0;
    for (int c = 0; c <= limit; c++) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (ready_o) begin
        lat = c;
        res = result_o;
        break;
      end
      next_cycle();
      if (scramble && c == 0) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
      end
    end
  endtask

  task automatic run_div(input vec_t v);
    int lat, stalls;
    logic [63:0] res;
    start_i      = 1'b1;
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    wait_ready(40, 1'b1, lat, res, stalls);
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " result"}, res, v.exp);
    chk({v.name, " stall cycles"}, 64'(stalls), 64'(v.lat));
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    chk({v.name, " ready pulse width"}, 64'(ready_o), 64'd0);
    next_cycle();
  endtask

  initial begin
    int lat, stalls;
    logic [63:0] res, prev;
    bit seen;

    vecs[0] = '{"divu 100/7",       1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         33};
    vecs[1] = '{"div -7/2",         1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},  33};
    vecs[2] = '{"div 7/-2",         1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD},  33};
    vecs[3] = '{"div overflow",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000},  33};
    vecs[4] = '{"divu 5/0",         1'b0, 32'd5,          32'd0,          64'd0,                            2};
    vecs[5] = '{"divu ffffffff/10", 1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF,          32'h0FFF_FFFF},  33};
    vecs[6] = '{"div -100/7",       1'b1, 32'hFFFF_FF9C,  32'd7,          {32'hFFFF_FFFE,  32'hFFFF_FFF2},  33};
    vecs[7] = '{"div 5/0",          1'b1, 32'hFFFF_FFFB,  32'd0,          64'd0,                            2};
    vecs[8] = '{"divu 80000000/3",  1'b0, 32'h8000_0000,  32'd3,          {32'd2,          32'h2AAA_AAAA},  33};
    vecs[9] = '{"div 0/-5",         1'b1, 32'd0,          32'hFFFF_FFFB,  64'd0,                            33};

    rst_n = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #12;
    chk("reset result", result_o, 64'd0);
    chk("reset ready", 64'(ready_o), 64'd0);
    start_i = 1'b1;
    #1;
    chk("reset stallreq follows start", 64'(stallreq_o), 64'd1);
    start_i = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 10; i++) run_div(vecs[i]);

    // Annul in cycle 10 of DIVU 100/7: no ready, result untouched.
    prev = result_o;
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (10) next_cycle();
    annul_i = 1'b1;
    next_cycle();
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
      next_cycle();
    end
    chk("annul no ready", 64'(seen), 64'd0);
    chk("annul result kept", result_o, prev);
    run_div('{"divu 9/4 after annul", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33});

    // start with annul in IDLE is ignored.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    repeat (3) next_cycle();
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
      next_cycle();
    end
    chk("idle annul ignored", 64'(seen), 64'd0);

    // Back-to-back with start held high.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    wait_ready(40, 1'b0, lat, res, stalls);
    chk("b2b first ready cycle", 64'(lat), 64'd33);
    chk("b2b first result", res, {32'd2, 32'd14});
    chk("b2b first stallreq low in result cycle", 64'(stallreq_o), 64'd0);
    next_cycle();
    opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'h10;
    wait_ready(40, 1'b0, lat, res, stalls);
    chk("b2b second ready cycle", 64'(lat + 34), 64'd67);
    chk("b2b second result", res, {32'hF, 32'h0FFF_FFFF});
    chk("b2b second stalls", 64'(stalls), 64'd33);
    next_cycle();
    start_i = 1'b0;
    next_cycle();

    // Reset in cycle 15, restart with start still high.
    start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (15) next_cycle();
    rst_n = 1'b0;
    #1;
    chk("midreset result cleared", result_o, 64'd0);
    chk("midreset ready cleared", 64'(ready_o), 64'd0);
    chk("midreset stallreq", 64'(stallreq_o), 64'd1);
    next_cycle();
    rst_n = 1'b1;
    wait_ready(40, 1'b0, lat, res, stalls);
    chk("post-reset latency", 64'(lat), 64'd33);
    chk("post-reset result", res, {32'd2, 32'd14});
    chk("post-reset stalls", 64'(stalls), 64'd33);
    next_cycle();
    start_i = 1'b0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
